// File: rtl/burst_access_controller_if.sv
// Bus between the serial front end / register bank and the burst access
// controller. The master side drives request words and bank read data;
// the slave side (the controller) drives bank writes and read returns.
interface burst_access_controller_if #(
    parameter int SIZE_WORD = 8,
    parameter int NREGWR    = 56,
    parameter int NREGR     = 8
);
    localparam int NREG = NREGWR + NREGR;
    localparam int AW   = $clog2(NREG);

    // Front end and bank side inputs to the controller
    logic [SIZE_WORD-1:0] dataw;
    logic                 valid;
    logic [SIZE_WORD-1:0] data_in;
    logic                 err_clr;

    // Controller outputs
    logic                 we;
    logic [SIZE_WORD-1:0] data_out;
    logic [AW-1:0]        addr;
    logic                 ready;
    logic [SIZE_WORD-1:0] datar;
    logic                 busy;
    logic                 err;

    modport master (
        output dataw, valid, data_in, err_clr,
        input  we, data_out, addr, ready, datar, busy, err
    );

    modport slave (
        input  dataw, valid, data_in, err_clr,
        output we, data_out, addr, ready, datar, busy, err
    );
endinterface

// File: rtl/burst_access_controller.sv
// Burst access controller: decodes header / length / data words from a
// serial front end into single or burst accesses on a register bank.
// Writable registers occupy 0..NREGWR-1, read-only ones NREGWR..NREG-1.
// The address pointer wraps at NREG, and protocol or access violations
// raise a sticky error flag that only err_clr removes.
module burst_access_controller #(
    parameter int SIZE_WORD = 8,
    parameter int NREGWR    = 56,
    parameter int NREGR     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    burst_access_controller_if.slave bus
);
    localparam int NREG = NREGWR + NREGR;
    localparam int AW   = $clog2(NREG);

    // Header needs a write bit and a burst bit above the address field.
    generate
        if (AW > SIZE_WORD - 2) begin : g_bad_cfg
            $error("burst_access_controller: address field does not fit in the header word");
        end
    endgenerate

    // Constants widened by one bit so that NREG and NREGWR themselves fit
    // even when the register count is an exact power of two.
    localparam logic [AW:0]   NREG_X   = (AW+1)'(NREG);
    localparam logic [AW:0]   NREGWR_X = (AW+1)'(NREGWR);
    localparam logic [AW-1:0] LAST_PTR = AW'(NREG - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_WRITE,
        S_READ,
        S_RDATA
    } state_t;

    state_t               state_q;
    logic                 dir_wr_q;   // direction latched from the header
    logic [AW-1:0]        ptr_q;
    logic [SIZE_WORD-1:0] cnt_q;
    logic                 we_q;
    logic [SIZE_WORD-1:0] data_out_q;
    logic [AW-1:0]        addr_q;
    logic                 ready_q;
    logic [SIZE_WORD-1:0] datar_q;
    logic                 err_q;

    logic [AW-1:0]        ptr_d;
    logic [SIZE_WORD-1:0] cnt_d;
    logic [AW-1:0]        hdr_addr_d;
    logic                 hdr_wr_d;
    logic                 hdr_burst_d;
    logic                 hdr_bad_d;
    logic                 wr_ok_d;

    // Header field extraction, wrapped pointer step and count step.
    always_comb begin
        hdr_addr_d  = bus.dataw[AW-1:0];
        hdr_wr_d    = bus.dataw[SIZE_WORD-1];
        hdr_burst_d = bus.dataw[SIZE_WORD-2];
        hdr_bad_d   = ({1'b0, hdr_addr_d} >= NREG_X);
        wr_ok_d     = ({1'b0, ptr_q} < NREGWR_X);
        ptr_d       = (ptr_q == LAST_PTR) ? '0 : ptr_q + AW'(1);
        cnt_d       = cnt_q - SIZE_WORD'(1);
    end

    // Transaction FSM with registered bank and return outputs. The error
    // clear is applied first so that any error set later in the same
    // cycle overrides it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            dir_wr_q   <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            data_out_q <= '0;
            addr_q     <= '0;
            ready_q    <= 1'b0;
            datar_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            if (bus.err_clr) begin
                err_q <= 1'b0;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (bus.valid) begin
                        if (hdr_bad_d) begin
                            err_q <= 1'b1;
                        end else begin
                            ptr_q    <= hdr_addr_d;
                            dir_wr_q <= hdr_wr_d;
                            if (hdr_burst_d) begin
                                state_q <= S_LEN;
                            end else begin
                                cnt_q   <= SIZE_WORD'(1);
                                state_q <= hdr_wr_d ? S_WRITE : S_READ;
                            end
                        end
                    end
                end

                S_LEN: begin
                    if (bus.valid) begin
                        if (bus.dataw == '0) begin
                            err_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q   <= bus.dataw;
                            state_q <= dir_wr_q ? S_WRITE : S_READ;
                        end
                    end
                end

                S_WRITE: begin
                    if (bus.valid) begin
                        addr_q     <= ptr_q;
                        data_out_q <= bus.dataw;
                        // Writes into the read-only region are dropped and flagged.
                        if (wr_ok_d) begin
                            we_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        ptr_q <= ptr_d;
                        cnt_q <= cnt_d;
                        if (cnt_q == SIZE_WORD'(1)) begin
                            state_q <= S_IDLE;
                        end
                    end
                end

                S_READ: begin
                    if (bus.valid) begin
                        addr_q  <= ptr_q;
                        ptr_q   <= ptr_d;
                        cnt_q   <= cnt_d;
                        state_q <= S_RDATA;
                    end
                end

                // Bank data for addr_q is valid now; valid is ignored here.
                S_RDATA: begin
                    datar_q <= bus.data_in;
                    ready_q <= 1'b1;
                    state_q <= (cnt_q != '0) ? S_READ : S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.we       = we_q;
    assign bus.data_out = data_out_q;
    assign bus.addr     = addr_q;
    assign bus.ready    = ready_q;
    assign bus.datar    = datar_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_burst_access_controller.sv
// Directed bench for burst_access_controller with a write/read scoreboard.
module tb_burst_access_controller;
    localparam int SW = 8;
    localparam int AW = 6;

    typedef struct {
        logic [AW-1:0] a;
        logic [SW-1:0] d;
        int            due;
    } exp_t;

    localparam int K_NONE = 0;
    localparam int K_WR   = 1;
    localparam int K_RD   = 2;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    exp_t wq[$];
    exp_t rq[$];

    burst_access_controller_if #(.SIZE_WORD(8), .NREGWR(56), .NREGR(8)) bif ();

    burst_access_controller #(.SIZE_WORD(8), .NREGWR(56), .NREGR(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    // Register bank read model: fixed pattern per address.
    function automatic logic [SW-1:0] pat(input logic [AW-1:0] a);
        return {a, 2'b10} ^ 8'hC3;
    endfunction

    assign bif.data_in = pat(bif.addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every we / ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bif.we === 1'b1) begin
                if (wq.size() == 0) begin
                    check("we_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = wq.pop_front();
                    check("wr_addr", 32'(bif.addr), 32'(e.a));
                    check("wr_data", 32'(bif.data_out), 32'(e.d));
                    check("wr_cycle", 32'(cyc), 32'(e.due));
                end
            end
            if (bif.ready === 1'b1) begin
                if (rq.size() == 0) begin
                    check("ready_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = rq.pop_front();
                    check("rd_data", 32'(bif.datar), 32'(e.d));
                    check("rd_cycle", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    // Drive one word for one cycle; optionally register the resulting access.
    task automatic send(input logic [SW-1:0] w, input int kind,
                        input logic [AW-1:0] a, input logic [SW-1:0] d);
        exp_t e;
        @(negedge clk);
        bif.dataw = w;
        bif.valid = 1'b1;
        e.a = a;
        e.d = d;
        if (kind == K_WR) begin
            e.due = cyc + 1;
            wq.push_back(e);
        end else if (kind == K_RD) begin
            e.due = cyc + 2;
            rq.push_back(e);
        end
        @(negedge clk);
        bif.valid = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        bif.err_clr = 1'b1;
        @(negedge clk);
        bif.err_clr = 1'b0;
    endtask

    initial begin
        exp_t e;
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rst   = 1'b0;
        bif.dataw   = '0;
        bif.valid   = 1'b0;
        bif.err_clr = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_we", 32'(bif.we), 32'd0);
        check("rst_ready", 32'(bif.ready), 32'd0);
        check("rst_err", 32'(bif.err), 32'd0);
        check("rst_addr", 32'(bif.addr), 32'd0);
        check("rst_data_out", 32'(bif.data_out), 32'd0);
        check("rst_datar", 32'(bif.datar), 32'd0);
        check("rst_busy", 32'(bif.busy), 32'd0);
        rst = 1'b1;

        // Single write 0x3C to address 5
        send(8'h85, K_NONE, '0, '0);
        check("single_busy_hdr", 32'(bif.busy), 32'd1);
        send(8'h3C, K_WR, 6'd5, 8'h3C);
        check("single_busy_after", 32'(bif.busy), 32'd0);
        check("single_err", 32'(bif.err), 32'd0);
        check("single_addr", 32'(bif.addr), 32'd5);

        // Burst write running into the read-only region
        send(8'hF6, K_NONE, '0, '0);
        send(8'h03, K_NONE, '0, '0);
        send(8'hA1, K_WR, 6'd54, 8'hA1);
        check("bw_busy_mid", 32'(bif.busy), 32'd1);
        send(8'hA2, K_WR, 6'd55, 8'hA2);
        send(8'hA3, K_NONE, '0, '0);
        check("bw_ro_addr", 32'(bif.addr), 32'd56);
        check("bw_ro_we", 32'(bif.we), 32'd0);
        check("bw_ro_err", 32'(bif.err), 32'd1);
        check("bw_idle", 32'(bif.busy), 32'd0);
        pulse_clr();
        check("bw_err_cleared", 32'(bif.err), 32'd0);

        // Burst read with pointer wrap; first word's valid is held into RDATA
        send(8'h7E, K_NONE, '0, '0);
        send(8'h03, K_NONE, '0, '0);
        @(negedge clk);
        bif.dataw = 8'h99;
        bif.valid = 1'b1;
        e.a   = 6'd62;
        e.d   = pat(6'd62);
        e.due = cyc + 2;
        rq.push_back(e);
        @(negedge clk);
        check("br_addr0", 32'(bif.addr), 32'd62);
        @(negedge clk);
        bif.valid = 1'b0;
        send(8'h00, K_RD, 6'd63, pat(6'd63));
        check("br_addr1", 32'(bif.addr), 32'd63);
        send(8'h00, K_RD, 6'd0, pat(6'd0));
        check("br_addr2", 32'(bif.addr), 32'd0);
        @(negedge clk);
        check("br_idle", 32'(bif.busy), 32'd0);
        check("br_err", 32'(bif.err), 32'd0);

        // Zero length burst, then clear, then clear coincident with new error
        send(8'hC0, K_NONE, '0, '0);
        send(8'h00, K_NONE, '0, '0);
        check("zl_err", 32'(bif.err), 32'd1);
        check("zl_busy", 32'(bif.busy), 32'd0);
        pulse_clr();
        check("zl_err_cleared", 32'(bif.err), 32'd0);
        send(8'hC0, K_NONE, '0, '0);
        @(negedge clk);
        bif.dataw   = 8'h00;
        bif.valid   = 1'b1;
        bif.err_clr = 1'b1;
        @(negedge clk);
        bif.valid   = 1'b0;
        bif.err_clr = 1'b0;
        check("zl_set_wins", 32'(bif.err), 32'd1);
        check("zl_busy2", 32'(bif.busy), 32'd0);
        pulse_clr();
        check("zl_err_cleared2", 32'(bif.err), 32'd0);

        // Reset in the middle of a length-4 burst write
        send(8'hC2, K_NONE, '0, '0);
        send(8'h04, K_NONE, '0, '0);
        send(8'h77, K_WR, 6'd2, 8'h77);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_we", 32'(bif.we), 32'd0);
        check("mid_rst_ready", 32'(bif.ready), 32'd0);
        check("mid_rst_busy", 32'(bif.busy), 32'd0);
        check("mid_rst_addr", 32'(bif.addr), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        send(8'h85, K_NONE, '0, '0);
        check("post_rst_hdr_busy", 32'(bif.busy), 32'd1);
        send(8'h11, K_WR, 6'd5, 8'h11);
        check("post_rst_addr", 32'(bif.addr), 32'd5);
        check("post_rst_err", 32'(bif.err), 32'd0);
        check("post_rst_busy", 32'(bif.busy), 32'd0);

        // Drain and confirm every expected access was seen
        repeat (4) @(negedge clk);
        check("wq_empty", 32'(wq.size()), 32'd0);
        check("rq_empty", 32'(rq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog: the directed sequence is short; anything longer is a hang.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
